// File: rtl/axi_ram_fill_pkg.sv
// Shared AXI encodings and FSM state type for axi_ram_fill.
// BURST_INCR, RESP_OKAY and the AWCACHE/AWPROT defaults are the same values used by the other
// AXI masters in this slice. BOUNDARY_BYTES is the AXI rule that a burst may not cross 4KB.
package axi_ram_fill_pkg;

  localparam logic [1:0] BURST_INCR      = 2'b01;
  localparam logic [1:0] RESP_OKAY       = 2'b00;
  localparam logic [3:0] AWCACHE_DEFAULT = 4'b0011;
  localparam logic [2:0] AWPROT_DEFAULT  = 3'b000;
  localparam int unsigned BOUNDARY_BYTES = 4096;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StResp
  } state_e;

endpackage

// File: rtl/axi_ram_fill.sv
// axi_ram_fill: AXI4 write-only master that fills a word-aligned RAM region with a constant or
// incrementing pattern (boot-time clear, scrub, test-pattern load).
// The region is split into INCR bursts that never cross a 4KB boundary. Only one burst is
// outstanding at a time.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   start             pulse; starts a fill when idle and is ignored while busy
//   cfg_addr          start byte address; the low log2(STRB_WIDTH) bits are ignored
//   cfg_len           number of beats to write; 0 means no AXI traffic and an immediate done
//   cfg_pattern       first data word
//   cfg_incr          1: data increments by 1 per beat; 0: data stays constant
//   busy              high while a fill is in progress
//   done              one-cycle pulse at completion
//   error             sticky flag for any non-OKAY bresp; cleared by an accepted start
//   m_axi_aw*/w*/b*   AXI4 write channels (no read channels)
module axi_ram_fill
  import axi_ram_fill_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH      = 8,
  parameter int unsigned AWID          = 0,
  parameter int unsigned MAX_BURST_LEN = 16,
  parameter int unsigned LEN_WIDTH     = ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [DATA_WIDTH-1:0] cfg_pattern,
  input  logic                  cfg_incr,
  output logic                  busy,
  output logic                  done,
  output logic                  error,

  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,

  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,

  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);

  localparam int unsigned SIZE_LOG = $clog2(STRB_WIDTH);
  // Comparison width wide enough for both the beat count and a 256-beat burst.
  localparam int unsigned CMP_W    = (LEN_WIDTH > 32) ? LEN_WIDTH : 32;

  // Beats in the next burst: min(remaining, MAX_BURST_LEN, beats left before the 4KB boundary).
  // The caller guarantees remaining > 0, so the result is in 1..256.
  function automatic logic [8:0] burst_beats(input logic [ADDR_WIDTH-1:0] addr,
                                             input logic [LEN_WIDTH-1:0]  remaining);
    logic [31:0]      n;
    logic [31:0]      to_bnd;
    logic [CMP_W-1:0] rem_w;
    n = MAX_BURST_LEN;
    if (ADDR_WIDTH > 12) begin
      to_bnd = (BOUNDARY_BYTES - (32'(addr) & (BOUNDARY_BYTES - 1))) >> SIZE_LOG;
      if (to_bnd < n) n = to_bnd;
    end
    rem_w = CMP_W'(remaining);
    if (rem_w < CMP_W'(n)) n = 32'(remaining);
    return n[8:0];
  endfunction

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [7:0]            awlen_q, awlen_d;
  logic                  awvalid_q, awvalid_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wlast_q, wlast_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  incr_q, incr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [8:0]            beats_q, beats_d;
  logic [8:0]            beat_left_q, beat_left_d;

  logic [ADDR_WIDTH-1:0] cfg_addr_al;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH-1:0] burst_addr;
  logic [LEN_WIDTH-1:0]  burst_rem;
  logic [8:0]            burst_n;
  logic                  load_burst;
  logic                  unused_bid;

  assign unused_bid  = ^m_axi_bid;

  assign cfg_addr_al = cfg_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
  assign next_addr   = awaddr_q + ADDR_WIDTH'(32'(beats_q) * STRB_WIDTH);
  // A new burst is sized either from the fresh config (idle) or from the running position.
  assign burst_addr  = (state_q == StIdle) ? cfg_addr_al : next_addr;
  assign burst_rem   = (state_q == StIdle) ? cfg_len : remaining_q;
  assign burst_n     = burst_beats(burst_addr, burst_rem);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (start && (cfg_len != '0)) state_d = StAddr;
      StAddr: if (m_axi_awready) state_d = StData;
      StData: if (m_axi_wready && wlast_q) state_d = StResp;
      StResp: if (m_axi_bvalid) state_d = (remaining_q == '0) ? StIdle : StAddr;
      default: state_d = StIdle;
    endcase
  end

  // Output and datapath next values; every output is registered below.
  always_comb begin
    awaddr_d    = awaddr_q;
    awlen_d     = awlen_q;
    awvalid_d   = awvalid_q;
    wdata_d     = wdata_q;
    wlast_d     = wlast_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    incr_d      = incr_q;
    remaining_d = remaining_q;
    beats_d     = beats_q;
    beat_left_d = beat_left_q;
    load_burst  = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          error_d = 1'b0;
          wdata_d = cfg_pattern;
          incr_d  = cfg_incr;
          if (cfg_len == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d     = 1'b1;
            load_burst = 1'b1;
          end
        end
      end
      StAddr: begin
        if (m_axi_awready) begin
          awvalid_d   = 1'b0;
          wvalid_d    = 1'b1;
          wlast_d     = (beats_q == 9'd1);
          beat_left_d = beats_q;
        end
      end
      StData: begin
        if (m_axi_wready) begin
          if (incr_q) wdata_d = wdata_q + 1'b1;
          if (wlast_q) begin
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
            bready_d = 1'b1;
          end else begin
            beat_left_d = beat_left_q - 9'd1;
            wlast_d     = (beat_left_q == 9'd2);
          end
        end
      end
      StResp: begin
        if (m_axi_bvalid) begin
          bready_d = 1'b0;
          // A failing burst is flagged but the fill carries on to the end of the region.
          if (m_axi_bresp != RESP_OKAY) error_d = 1'b1;
          if (remaining_q == '0) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            load_burst = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (load_burst) begin
      awaddr_d    = burst_addr;
      awlen_d     = 8'(burst_n - 9'd1);
      awvalid_d   = 1'b1;
      beats_d     = burst_n;
      remaining_d = burst_rem - LEN_WIDTH'(burst_n);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      awaddr_q    <= '0;
      awlen_q     <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= '0;
      wlast_q     <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      incr_q      <= 1'b0;
      remaining_q <= '0;
      beats_q     <= '0;
      beat_left_q <= '0;
    end else begin
      awaddr_q    <= awaddr_d;
      awlen_q     <= awlen_d;
      awvalid_q   <= awvalid_d;
      wdata_q     <= wdata_d;
      wlast_q     <= wlast_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      incr_q      <= incr_d;
      remaining_q <= remaining_d;
      beats_q     <= beats_d;
      beat_left_q <= beat_left_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;

  assign m_axi_awid    = ID_WIDTH'(AWID);
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = 3'(SIZE_LOG);
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = AWCACHE_DEFAULT;
  assign m_axi_awprot  = AWPROT_DEFAULT;
  assign m_axi_awvalid = awvalid_q;

  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = wlast_q;
  assign m_axi_wvalid  = wvalid_q;

  assign m_axi_bready  = bready_q;

endmodule

// File: tb/tb_axi_ram_fill.sv
// Directed bench for axi_ram_fill: a behavioural AXI RAM slave with optional random stalls and an
// injectable error response, plus monitors for burst shape, handshake stability and data.
module tb_axi_ram_fill;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] cfg_addr = '0;
  logic [15:0] cfg_len = '0;
  logic [31:0] cfg_pattern = '0;
  logic        cfg_incr = 1'b0;
  logic        busy, done, error;

  logic [7:0]  awid;
  logic [15:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [7:0]  bid = '0;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axi_ram_fill dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_addr     (cfg_addr),
    .cfg_len      (cfg_len),
    .cfg_pattern  (cfg_pattern),
    .cfg_incr     (cfg_incr),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .m_axi_awid   (awid),
    .m_axi_awaddr (awaddr),
    .m_axi_awlen  (awlen),
    .m_axi_awsize (awsize),
    .m_axi_awburst(awburst),
    .m_axi_awlock (awlock),
    .m_axi_awcache(awcache),
    .m_axi_awprot (awprot),
    .m_axi_awvalid(awvalid),
    .m_axi_awready(awready),
    .m_axi_wdata  (wdata),
    .m_axi_wstrb  (wstrb),
    .m_axi_wlast  (wlast),
    .m_axi_wvalid (wvalid),
    .m_axi_wready (wready),
    .m_axi_bid    (bid),
    .m_axi_bresp  (bresp),
    .m_axi_bvalid (bvalid),
    .m_axi_bready (bready)
  );

  // ---------------- slave model and monitors ----------------
  logic [31:0] mem [0:16383];
  logic [15:0] aw_log_addr [0:255];
  logic [7:0]  aw_log_len  [0:255];
  int          wlast_log   [0:255];

  logic        stall = 1'b0;
  int          err_burst = -1;

  logic        have_aw, b_pend;
  logic [15:0] cur_addr;
  logic [7:0]  cur_len;
  int          wbeat;
  logic        aw_hold, w_hold;
  logic [15:0] aw_hold_addr;
  logic [7:0]  aw_hold_len;
  logic [31:0] w_hold_data;
  logic        w_hold_last;

  int aw_cnt = 0, b_cnt = 0, wtotal = 0, wlast_cnt = 0;
  int cross_cnt = 0, w_early = 0, wlast_bad = 0, aw_stab_err = 0, w_stab_err = 0;
  int done_cnt = 0, busy_cycles = 0, awv_cycles = 0;

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (busy) busy_cycles <= busy_cycles + 1;
    if (awvalid) awv_cycles <= awv_cycles + 1;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= 2'b00;
      have_aw <= 1'b0;
      b_pend  <= 1'b0;
      wbeat   <= 0;
      aw_hold <= 1'b0;
      w_hold  <= 1'b0;
    end else begin
      awready <= stall ? 1'($urandom_range(0, 1)) : 1'b1;
      wready  <= stall ? 1'($urandom_range(0, 1)) : 1'b1;

      aw_hold      <= awvalid && !awready;
      aw_hold_addr <= awaddr;
      aw_hold_len  <= awlen;
      w_hold       <= wvalid && !wready;
      w_hold_data  <= wdata;
      w_hold_last  <= wlast;
      if (aw_hold && (!awvalid || awaddr != aw_hold_addr || awlen != aw_hold_len))
        aw_stab_err <= aw_stab_err + 1;
      if (w_hold && (!wvalid || wdata != w_hold_data || wlast != w_hold_last))
        w_stab_err <= w_stab_err + 1;

      if (awvalid && awready) begin
        aw_log_addr[aw_cnt] <= awaddr;
        aw_log_len[aw_cnt]  <= awlen;
        aw_cnt              <= aw_cnt + 1;
        if ((32'(awaddr) & 32'hFFF) + (32'(awlen) + 1) * 4 > 4096) cross_cnt <= cross_cnt + 1;
        have_aw  <= 1'b1;
        cur_addr <= awaddr;
        cur_len  <= awlen;
        wbeat    <= 0;
      end

      if (wvalid && wready) begin
        if (!have_aw) w_early <= w_early + 1;
        mem[cur_addr[15:2] + 14'(wbeat)] <= wdata;
        wbeat  <= wbeat + 1;
        wtotal <= wtotal + 1;
        if (wlast != (wbeat == int'(cur_len))) wlast_bad <= wlast_bad + 1;
        if (wlast) begin
          wlast_log[wlast_cnt] <= wtotal + 1;
          wlast_cnt <= wlast_cnt + 1;
          have_aw   <= 1'b0;
          b_pend    <= 1'b1;
        end
      end

      if (bvalid && bready) begin
        bvalid <= 1'b0;
        b_cnt  <= b_cnt + 1;
      end else if (b_pend && !bvalid && (!stall || $urandom_range(0, 1) == 1)) begin
        bvalid <= 1'b1;
        bresp  <= (b_cnt == err_burst) ? 2'b10 : 2'b00;
        b_pend <= 1'b0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [15:0] a, input logic [15:0] l, input logic [31:0] p,
                    input logic inc);
    cfg_addr    = a;
    cfg_len     = l;
    cfg_pattern = p;
    cfg_incr    = inc;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic check_mem(input string tag, input logic [15:0] base, input int n,
                           input logic [31:0] first, input logic inc);
    int bad = 0;
    logic [31:0] e = first;
    for (int i = 0; i < n; i++) begin
      if (mem[base[15:2] + 14'(i)] !== e) bad++;
      if (inc) e = e + 1;
    end
    chk(tag, 64'(bad), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  int a0, d0, t0, k0, b0, n;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 64'({awvalid, wvalid, bready, busy, done, error, wlast}), 64'd0);
    chk("rst_awaddr", 64'(awaddr), 64'd0);
    chk("rst_awlen", 64'(awlen), 64'd0);
    chk("rst_wdata", 64'(wdata), 64'd0);
    chk("const_aw", 64'({awsize, awburst, awlock, awcache, awprot}),
        64'({3'd2, 2'b01, 1'b0, 4'b0011, 3'b000}));
    chk("const_wstrb", 64'(wstrb), 64'hF);
    rst = 1'b0;
    @(negedge clk);

    // 1: constant fill, three bursts; a start while busy is ignored
    a0 = aw_cnt; d0 = done_cnt;
    go(16'h0100, 16'd40, 32'hA5A5A5A5, 1'b0);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_awvalid", 64'(awvalid), 64'd1);
    repeat (3) @(negedge clk);
    go(16'h8000, 16'd1, 32'h12345678, 1'b1);
    wait_done("t1", 2000);
    repeat (4) @(negedge clk);
    chk("t1_bursts", 64'(aw_cnt - a0), 64'd3);
    chk("t1_lens", 64'({aw_log_len[a0], aw_log_len[a0+1], aw_log_len[a0+2]}), 64'h0F0F07);
    chk("t1_addrs", 64'({aw_log_addr[a0], aw_log_addr[a0+1], aw_log_addr[a0+2]}),
        64'h0100_0140_0180);
    check_mem("t1_mem", 16'h0100, 40, 32'hA5A5A5A5, 1'b0);
    chk("t1_done_once", 64'(done_cnt - d0), 64'd1);
    chk("t1_err_busy", 64'({error, busy}), 64'd0);

    // 2: 4KB split
    a0 = aw_cnt;
    go(16'h0FF0, 16'd8, 32'h10, 1'b1);
    wait_done("t2", 1000);
    repeat (2) @(negedge clk);
    chk("t2_bursts", 64'(aw_cnt - a0), 64'd2);
    chk("t2_b0", 64'({aw_log_addr[a0], aw_log_len[a0]}), 64'h0FF0_03);
    chk("t2_b1", 64'({aw_log_addr[a0+1], aw_log_len[a0+1]}), 64'h1000_03);
    check_mem("t2_mem", 16'h0FF0, 8, 32'h10, 1'b1);
    chk("t2_cross", 64'(cross_cnt), 64'd0);

    // 3: zero length
    a0 = aw_cnt; d0 = awv_cycles; t0 = busy_cycles;
    go(16'h0200, 16'd0, 32'h1, 1'b0);
    chk("t3_done", 64'({done, busy}), 64'b10);
    @(negedge clk);
    chk("t3_done_drop", 64'({done, busy}), 64'b00);
    repeat (5) @(negedge clk);
    chk("t3_no_aw", 64'(awv_cycles - d0), 64'd0);
    chk("t3_no_busy", 64'(busy_cycles - t0), 64'd0);
    chk("t3_no_burst", 64'(aw_cnt - a0), 64'd0);

    // 4: random stalls
    stall = 1'b1;
    a0 = aw_cnt; k0 = wlast_cnt; t0 = wtotal;
    go(16'h2000, 16'd33, 32'h1000, 1'b1);
    wait_done("t4", 4000);
    stall = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_bursts", 64'(aw_cnt - a0), 64'd3);
    check_mem("t4_mem", 16'h2000, 33, 32'h1000, 1'b1);
    chk("t4_wlast_pos", 64'({16'(wlast_log[k0] - t0), 16'(wlast_log[k0+1] - t0),
                             16'(wlast_log[k0+2] - t0)}), 64'h0010_0020_0021);
    chk("t4_aw_stable", 64'(aw_stab_err), 64'd0);
    chk("t4_w_stable", 64'(w_stab_err), 64'd0);
    chk("t4_wlast_ok", 64'(wlast_bad), 64'd0);
    chk("t4_no_early_w", 64'(w_early), 64'd0);

    // 5: SLVERR on the second of three bursts
    b0 = b_cnt; a0 = aw_cnt;
    err_burst = b0 + 1;
    go(16'h3000, 16'd48, 32'h0, 1'b0);
    n = 0;
    while (b_cnt < b0 + 1 && n < 1000) begin @(negedge clk); n++; end
    chk("t5_err_b1", 64'({error, busy}), 64'b01);
    n = 0;
    while (b_cnt < b0 + 2 && n < 1000) begin @(negedge clk); n++; end
    chk("t5_err_b2", 64'({error, busy}), 64'b11);
    wait_done("t5", 1000);
    chk("t5_err_end", 64'(error), 64'd1);
    chk("t5_bursts", 64'(aw_cnt - a0), 64'd3);
    err_burst = -1;
    @(negedge clk);
    go(16'h3400, 16'd4, 32'h55, 1'b0);
    chk("t5_err_cleared", 64'(error), 64'd0);
    wait_done("t5b", 500);
    chk("t5b_err", 64'(error), 64'd0);
    check_mem("t5b_mem", 16'h3400, 4, 32'h55, 1'b0);

    // 6: reset during the data phase, then a clean fill
    @(negedge clk);
    go(16'h4000, 16'd64, 32'hDEAD0000, 1'b1);
    n = 0;
    while (!wvalid && n < 200) begin @(negedge clk); n++; end
    chk("t6_in_data", 64'(wvalid), 64'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_ctrl", 64'({awvalid, wvalid, bready, busy, done, error, wlast}), 64'd0);
    chk("t6_rst_data", 64'({awaddr, awlen, wdata}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    a0 = aw_cnt;
    go(16'h5000, 16'd4, 32'h77, 1'b1);
    wait_done("t6", 500);
    repeat (2) @(negedge clk);
    chk("t6_burst", 64'({aw_log_addr[a0], aw_log_len[a0], 8'(aw_cnt - a0)}), 64'h5000_03_01);
    check_mem("t6_mem", 16'h5000, 4, 32'h77, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
